// File: rtl/cafe_arbiter_pkg.sv
// rtl/cafe_arbiter_pkg.sv - shared states, drink codes and default sizes for the cafe arbiter
package cafe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BREW,
    DONE,
    FAULT
  } state_t;

  localparam logic [1:0] CAFE       = 2'b00;
  localparam logic [1:0] CAFE_LONGO = 2'b01;
  localparam logic [1:0] COM_LEITE  = 2'b10;
  localparam logic [1:0] INVALIDO   = 2'b11;

  localparam int N_REQ_DEF   = 3;
  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/cafe_arbiter_if.sv
// rtl/cafe_arbiter_if.sv - order panel and brewer signal bundle for the cafe arbiter
interface cafe_arbiter_if #(
  parameter int N_REQ = cafe_pkg::N_REQ_DEF,
  parameter int CNT_W = cafe_pkg::CNT_W_DEF
);

  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] tipo_req;
  logic               err_clr;
  logic               brew_c;
  logic               brew_l;
  logic               brew_f;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   grant;
  logic               brew_start;
  logic [1:0]         brew_tipo;
  logic [CNT_W-1:0]   served_cnt;
  logic               err;

  // panels and brewer side
  modport master (
    output req, tipo_req, err_clr, brew_c, brew_l, brew_f,
    input  ack, grant, brew_start, brew_tipo, served_cnt, err
  );

  // arbiter side
  modport slave (
    input  req, tipo_req, err_clr, brew_c, brew_l, brew_f,
    output ack, grant, brew_start, brew_tipo, served_cnt, err
  );

endinterface

// File: rtl/cafe_arbiter_rr.sv
// rtl/cafe_arbiter_rr.sv - combinational round-robin pick starting after the last served panel
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  int idx;

  // scan last+1, last+2, ... wrapping, and keep the first pending panel found
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!valid && pending[idx]) begin
        valid  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cafe_arbiter.sv
// rtl/cafe_arbiter.sv - shares one brewer among several order panels with a timeout watchdog
module cafe_arbiter
  import cafe_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic          clock,
  input  logic          reset,
  cafe_arbiter_if.slave bus
);

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           next_state;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] clr_mask;
  logic [1:0]       codes [N_REQ];
  logic [IW-1:0]    winner;
  logic [IW-1:0]    last_served;
  logic [IW-1:0]    rr_winner;
  logic             rr_valid;
  logic [N_REQ-1:0] rr_onehot;
  logic [N_REQ-1:0] win_onehot;
  logic             clear_win;
  logic [WD_W-1:0]  wd;

  logic [N_REQ-1:0] ack_reg;
  logic [N_REQ-1:0] grant_reg;
  logic             brew_start_reg;
  logic [1:0]       brew_tipo_reg;
  logic [CNT_W-1:0] served_reg;
  logic             err_reg;

  // brew_c/brew_l are status for observers only; they never steer the machine
  logic unused_obs;
  assign unused_obs = bus.brew_c ^ bus.brew_l;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .pending (pending),
    .last    (last_served),
    .winner  (rr_winner),
    .valid   (rr_valid)
  );

  assign rr_onehot  = N_REQ'(1) << rr_winner;
  assign win_onehot = N_REQ'(1) << winner;
  assign clr_mask   = clear_win ? win_onehot : '0;

  // a panel is accepted only when idle on our side and asking for a real drink
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_REQ; i++) begin
      accept[i] = bus.req[i] && !pending[i] && (bus.tipo_req[2*i +: 2] != INVALIDO);
    end
  end

  // next state; brew_f is checked before the watchdog so a late finish still counts
  always_comb begin
    next_state = state;
    clear_win  = 1'b0;
    case (state)
      IDLE:  if (rr_valid) next_state = START;
      START: next_state = BREW;
      BREW: begin
        if (bus.brew_f)                 next_state = DONE;
        else if (wd == WD_W'(TIMEOUT))  next_state = FAULT;
      end
      DONE: begin
        next_state = IDLE;
        clear_win  = 1'b1;
      end
      FAULT: begin
        if (bus.err_clr) begin
          next_state = IDLE;
          clear_win  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // state, order bookkeeping and registered outputs derived from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      pending        <= '0;
      winner         <= '0;
      last_served    <= IW'(N_REQ - 1);
      wd             <= '0;
      ack_reg        <= '0;
      grant_reg      <= '0;
      brew_start_reg <= 1'b0;
      brew_tipo_reg  <= CAFE;
      served_reg     <= '0;
      err_reg        <= 1'b0;
      for (int i = 0; i < N_REQ; i++) codes[i] <= CAFE;
    end else begin
      state   <= next_state;
      pending <= (pending | accept) & ~clr_mask;
      ack_reg <= accept;
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) codes[i] <= bus.tipo_req[2*i +: 2];
      end

      if (state == IDLE && rr_valid) begin
        winner        <= rr_winner;
        brew_tipo_reg <= codes[rr_winner];
      end

      case (next_state)
        START:   grant_reg <= rr_onehot;
        BREW:    grant_reg <= grant_reg;
        default: grant_reg <= '0;
      endcase
      brew_start_reg <= (next_state == START);
      err_reg        <= (next_state == FAULT);

      if (next_state == BREW) wd <= (state == START) ? WD_W'(1) : wd + WD_W'(1);
      else                    wd <= '0;

      if (state == DONE) begin
        last_served <= winner;
        if (served_reg != '1) served_reg <= served_reg + CNT_W'(1);
      end
    end
  end

  assign bus.ack        = ack_reg;
  assign bus.grant      = grant_reg;
  assign bus.brew_start = brew_start_reg;
  assign bus.brew_tipo  = brew_tipo_reg;
  assign bus.served_cnt = served_reg;
  assign bus.err        = err_reg;

endmodule
